// File: rtl/dpram_arbiter.sv
// ---------------------------------------------------------------------------
// dpram_arbiter
//   Arbitrates two write requesters and two read requesters onto a simple
//   dual-port RAM (port 0 write-only, port 1 read-only). Each side has its
//   own round-robin arbiter and accepts at most one request per cycle.
//
//   Write path: accept in T -> port-0 strobe/address/data registered for T+1.
//   Read path : accept in T -> port-1 enable/address in T+1 -> rvalid in T+2
//               (the RAM registers dout1 at the end of T+1).
//   A read whose address matches the write currently on port 0 is held off
//   for one cycle, so the read is issued after that write has landed.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   wN_valid/ready/addr/data     write requester N (N = 0,1)
//   rN_valid/ready/addr          read request, requester N
//   rN_rvalid/rdata              read response, requester N
//   wr_en, port_enable_0,
//   din, address_in_0            RAM port 0 (write)
//   port_enable_1, address_in_1  RAM port 1 (read)
//   dout1                        RAM port 1 read data
// ---------------------------------------------------------------------------

// Two-way round-robin arbiter. Grant is combinational; the pointer names the
// requester that wins a tie and moves to the other requester after a grant.
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);
    logic r_ptr;

    always_comb begin
        o_gnt = 2'b00;
        if (!i_rst) begin
            if (i_req == 2'b11)
                o_gnt = r_ptr ? 2'b10 : 2'b01;
            else
                o_gnt = i_req;
        end
    end

    // Granting 0 hands priority to 1 and vice versa, i.e. ptr := gnt[0].
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_ptr <= 1'b0;
        else if (|o_gnt)
            r_ptr <= o_gnt[0];
    end
endmodule

module dpram_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    // write requesters
    input  logic              w0_valid,
    output logic              w0_ready,
    input  logic [ADDR_W-1:0] w0_addr,
    input  logic [DATA_W-1:0] w0_data,
    input  logic              w1_valid,
    output logic              w1_ready,
    input  logic [ADDR_W-1:0] w1_addr,
    input  logic [DATA_W-1:0] w1_data,
    // read requesters
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [ADDR_W-1:0] r0_addr,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [ADDR_W-1:0] r1_addr,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    // RAM port 0 (write)
    output logic              wr_en,
    output logic              port_enable_0,
    output logic [DATA_W-1:0] din,
    output logic [ADDR_W-1:0] address_in_0,
    // RAM port 1 (read)
    output logic              port_enable_1,
    output logic [ADDR_W-1:0] address_in_1,
    input  logic [DATA_W-1:0] dout1
);
    logic [1:0]        w_wreq, w_wgnt;
    logic [1:0]        w_rreq, w_rgnt;
    logic              w_haz0, w_haz1;

    logic              r_wr_en;
    logic [DATA_W-1:0] r_din;
    logic [ADDR_W-1:0] r_waddr;
    logic              r_rd_en;
    logic              r_rd_sel;    // which requester owns the read on port 1
    logic [ADDR_W-1:0] r_raddr;
    logic [1:0]        r_rvalid;

    // Write arbitration
    assign w_wreq = {w1_valid, w0_valid};

    rr_arb2 u_warb (
        .i_clk (clk),
        .i_rst (rst),
        .i_req (w_wreq),
        .o_gnt (w_wgnt)
    );

    // A read matching the write on port 0 this cycle is masked out of
    // arbitration, so the other reader can still win and the pointer only
    // moves on a real grant.
    assign w_haz0 = r_wr_en && (r_waddr == r0_addr);
    assign w_haz1 = r_wr_en && (r_waddr == r1_addr);
    assign w_rreq = {r1_valid && !w_haz1, r0_valid && !w_haz0};

    rr_arb2 u_rarb (
        .i_clk (clk),
        .i_rst (rst),
        .i_req (w_rreq),
        .o_gnt (w_rgnt)
    );

    assign w0_ready = w_wgnt[0];
    assign w1_ready = w_wgnt[1];
    assign r0_ready = w_rgnt[0];
    assign r1_ready = w_rgnt[1];

    // Write stage: strobe for exactly one cycle, data/address hold between
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_en <= 1'b0;
            r_din   <= '0;
            r_waddr <= '0;
        end else begin
            r_wr_en <= |w_wgnt;
            if (w_wgnt[1]) begin
                r_din   <= w1_data;
                r_waddr <= w1_addr;
            end else if (w_wgnt[0]) begin
                r_din   <= w0_data;
                r_waddr <= w0_addr;
            end
        end
    end

    // Read stages: issue to port 1, then flag the owner when dout1 is valid.
    // Reset clears both stages, dropping any read still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_en  <= 1'b0;
            r_rd_sel <= 1'b0;
            r_raddr  <= '0;
            r_rvalid <= 2'b00;
        end else begin
            r_rd_en  <= |w_rgnt;
            r_rvalid <= {r_rd_en && r_rd_sel, r_rd_en && !r_rd_sel};
            if (w_rgnt[1]) begin
                r_rd_sel <= 1'b1;
                r_raddr  <= r1_addr;
            end else if (w_rgnt[0]) begin
                r_rd_sel <= 1'b0;
                r_raddr  <= r0_addr;
            end
        end
    end

    assign wr_en         = r_wr_en;
    assign port_enable_0 = r_wr_en;
    assign din           = r_din;
    assign address_in_0  = r_waddr;
    assign port_enable_1 = r_rd_en;
    assign address_in_1  = r_raddr;
    assign r0_rvalid     = r_rvalid[0];
    assign r1_rvalid     = r_rvalid[1];
    assign r0_rdata      = dout1;
    assign r1_rdata      = dout1;
endmodule

// File: tb/tb_dpram_arbiter.sv
// Bench for dpram_arbiter: directed scenarios plus a randomized run, all
// checked against a transaction-level model (memory image + queue of
// scheduled read returns) kept in this file.
module tb_dpram_arbiter;
    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk;
    logic          rst;
    logic          w0_valid, w1_valid, r0_valid, r1_valid;
    logic [AW-1:0] w0_addr, w1_addr, r0_addr, r1_addr;
    logic [DW-1:0] w0_data, w1_data;
    logic          w0_ready, w1_ready, r0_ready, r1_ready;
    logic          r0_rvalid, r1_rvalid;
    logic [DW-1:0] r0_rdata, r1_rdata;
    logic          wr_en, port_enable_0, port_enable_1;
    logic [DW-1:0] din;
    logic [AW-1:0] address_in_0, address_in_1;
    logic [DW-1:0] dout1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    dpram_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .w0_valid(w0_valid), .w0_ready(w0_ready), .w0_addr(w0_addr), .w0_data(w0_data),
        .w1_valid(w1_valid), .w1_ready(w1_ready), .w1_addr(w1_addr), .w1_data(w1_data),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_addr(r0_addr),
        .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_addr(r1_addr),
        .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .wr_en(wr_en), .port_enable_0(port_enable_0), .din(din), .address_in_0(address_in_0),
        .port_enable_1(port_enable_1), .address_in_1(address_in_1), .dout1(dout1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural dual-port RAM, read-first on a same-edge collision
    logic [DW-1:0] ram [16] = '{default: 8'h00};
    always @(posedge clk) begin
        if (port_enable_1) dout1 <= ram[address_in_1];
        if (wr_en && port_enable_0) ram[address_in_0] <= din;
    end

    // ---------------- reference model ----------------
    typedef struct { int due; bit idx; logic [DW-1:0] data; } rd_t;
    rd_t           rq[$];
    logic [DW-1:0] mmem [16] = '{default: 8'h00};
    int            m_wptr = 0, m_rptr = 0;
    bit            ws_v = 0, rs_v = 0;          // write/read reaching the RAM next cycle
    logic [AW-1:0] ws_a = '0, rs_a = '0;
    logic [DW-1:0] ws_d = '0;
    // expectations for the current cycle
    bit            e_wg0, e_wg1, e_rg0, e_rg1, e_wr_en, e_pe1, e_rv0, e_rv1;
    logic [AW-1:0] e_a0, e_a1;
    logic [DW-1:0] e_din, e_rdata;

    task automatic model_eval();
        bit ok0, ok1;
        e_wg0 = 0; e_wg1 = 0; e_rg0 = 0; e_rg1 = 0;
        if (!rst) begin
            if (w0_valid && w1_valid) begin
                e_wg0 = (m_wptr == 0); e_wg1 = (m_wptr == 1);
            end else begin
                e_wg0 = w0_valid; e_wg1 = w1_valid;
            end
            ok0 = r0_valid && !(ws_v && ws_a == r0_addr);
            ok1 = r1_valid && !(ws_v && ws_a == r1_addr);
            if (ok0 && ok1) begin
                e_rg0 = (m_rptr == 0); e_rg1 = (m_rptr == 1);
            end else begin
                e_rg0 = ok0; e_rg1 = ok1;
            end
        end
        e_wr_en = ws_v; e_a0 = ws_a; e_din = ws_d;
        e_pe1 = rs_v; e_a1 = rs_a;
        e_rv0 = 0; e_rv1 = 0; e_rdata = '0;
        foreach (rq[k]) if (rq[k].due == cyc) begin
            if (rq[k].idx) e_rv1 = 1; else e_rv0 = 1;
            e_rdata = rq[k].data;
        end
    endtask

    task automatic model_commit();
        bit g;
        logic [AW-1:0] a;
        while (rq.size() > 0 && rq[0].due <= cyc) void'(rq.pop_front());
        if (rst) begin
            m_wptr = 0; m_rptr = 0; ws_v = 0; rs_v = 0;
            ws_a = '0; ws_d = '0; rs_a = '0;
            rq.delete();
        end else begin
            // Reads see every write accepted in earlier cycles only
            rs_v = e_rg0 | e_rg1;
            if (rs_v) begin
                g = e_rg1; a = g ? r1_addr : r0_addr;
                rq.push_back('{cyc + 2, g, mmem[a]});
                rs_a = a; m_rptr = g ? 0 : 1;
            end
            ws_v = e_wg0 | e_wg1;
            if (ws_v) begin
                g = e_wg1;
                ws_a = g ? w1_addr : w0_addr;
                ws_d = g ? w1_data : w0_data;
                mmem[ws_a] = ws_d;
                m_wptr = g ? 0 : 1;
            end
        end
    endtask

    task automatic settle();
        #2;
        model_eval();
    endtask

    task automatic advance();
        model_commit();
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle_inputs();
        w0_valid = 0; w1_valid = 0; r0_valid = 0; r1_valid = 0;
    endtask

    task automatic do_reset();
        rst = 1; settle(); advance(); rst = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1;
        w0_valid = 1; w1_valid = 1; r0_valid = 1; r1_valid = 1;
        w0_addr = 4'd1; w1_addr = 4'd2; r0_addr = 4'd3; r1_addr = 4'd4;
        for (int i = 0; i < 3; i++) begin
            settle();
            total++;
            if ({w0_ready, w1_ready, r0_ready, r1_ready} !== 4'b0000) begin
                bad++; $display("FAIL reset_ready got=%b want=0000", {w0_ready, w1_ready, r0_ready, r1_ready});
            end
            total++;
            if ({wr_en, port_enable_0, port_enable_1, r0_rvalid, r1_rvalid} !== 5'b0) begin
                bad++; $display("FAIL reset_strobes got=%b want=00000",
                                {wr_en, port_enable_0, port_enable_1, r0_rvalid, r1_rvalid});
            end
            total++;
            if (din !== 8'h00 || address_in_0 !== 4'h0 || address_in_1 !== 4'h0) begin
                bad++; $display("FAIL reset_regs got din=%h a0=%h a1=%h want 0", din, address_in_0, address_in_1);
            end
            advance();
        end
        rst = 0;
        idle_inputs();
    endtask

    task automatic test_single_write();
        w0_valid = 1; w0_addr = 4'd3; w0_data = 8'hA5;
        settle();
        total++;
        if ({w1_ready, w0_ready} !== 2'b01) begin
            bad++; $display("FAIL single_wready got=%b want=01", {w1_ready, w0_ready});
        end
        advance();
        w0_valid = 0;
        settle();
        total++;
        if ({wr_en, port_enable_0} !== 2'b11 || address_in_0 !== 4'd3 || din !== 8'hA5) begin
            bad++; $display("FAIL single_port0 got en=%b a=%0d d=%h want 11 3 a5",
                            {wr_en, port_enable_0}, address_in_0, din);
        end
        advance();
        settle();
        total++;
        if ({wr_en, port_enable_0} !== 2'b00 || din !== 8'hA5) begin
            bad++; $display("FAIL single_hold got en=%b d=%h want 00 a5", {wr_en, port_enable_0}, din);
        end
        advance();
    endtask

    task automatic test_write_alt();
        logic [1:0] want;
        do_reset();
        w0_valid = 1; w0_addr = 4'd1; w0_data = 8'h11;
        w1_valid = 1; w1_addr = 4'd2; w1_data = 8'h22;
        for (int i = 0; i < 4; i++) begin
            settle();
            want = (i % 2 == 1) ? 2'b10 : 2'b01;
            total++;
            if ({w1_ready, w0_ready} !== want) begin
                bad++; $display("FAIL alt_grant%0d got=%b want=%b", i, {w1_ready, w0_ready}, want);
            end
            if (i > 0) begin
                total++;
                if (wr_en !== 1'b1 || address_in_0 !== ((i % 2 == 1) ? 4'd1 : 4'd2) ||
                    din !== ((i % 2 == 1) ? 8'h11 : 8'h22)) begin
                    bad++; $display("FAIL alt_ram%0d got en=%b a=%0d d=%h", i, wr_en, address_in_0, din);
                end
            end
            advance();
        end
        idle_inputs();
        settle();
        total++;
        if (wr_en !== 1'b1 || address_in_0 !== 4'd2 || din !== 8'h22) begin
            bad++; $display("FAIL alt_last got en=%b a=%0d d=%h want 1 2 22", wr_en, address_in_0, din);
        end
        advance();
    endtask

    task automatic test_fill_readback();
        for (int a = 0; a < 16; a++) begin
            w1_valid = 1; w1_addr = 4'(a); w1_data = 8'(a + 1);
            settle();
            total++;
            if (w1_ready !== 1'b1) begin
                bad++; $display("FAIL fill_ready a=%0d got=%b want=1", a, w1_ready);
            end
            advance();
        end
        w1_valid = 0;
        for (int i = 0; i < 19; i++) begin
            r0_valid = (i < 16); r0_addr = 4'(i);
            settle();
            if (i < 16) begin
                total++;
                if (r0_ready !== 1'b1) begin
                    bad++; $display("FAIL rb_ready i=%0d got=%b want=1", i, r0_ready);
                end
            end
            total++;
            if (r0_rvalid !== (i >= 2 && i < 18) || r1_rvalid !== 1'b0) begin
                bad++; $display("FAIL rb_rvalid i=%0d got=%b%b", i, r1_rvalid, r0_rvalid);
            end
            if (i >= 2 && i < 18) begin
                total++;
                if (r0_rdata !== 8'(i - 1)) begin
                    bad++; $display("FAIL rb_data i=%0d got=%h want=%h", i, r0_rdata, 8'(i - 1));
                end
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_hazard();
        w0_valid = 1; w0_addr = 4'd7; w0_data = 8'h3C;
        settle();
        total++;
        if (w0_ready !== 1'b1) begin
            bad++; $display("FAIL haz_wready got=%b want=1", w0_ready);
        end
        advance();
        w0_valid = 0; r1_valid = 1; r1_addr = 4'd7;
        settle();
        total++;
        if (wr_en !== 1'b1 || address_in_0 !== 4'd7 || r1_ready !== 1'b0) begin
            bad++; $display("FAIL haz_hold got en=%b a=%0d r1_ready=%b want 1 7 0", wr_en, address_in_0, r1_ready);
        end
        advance();
        settle();
        total++;
        if (r1_ready !== 1'b1) begin
            bad++; $display("FAIL haz_accept got=%b want=1", r1_ready);
        end
        advance();
        r1_valid = 0;
        settle();
        total++;
        if (port_enable_1 !== 1'b1 || address_in_1 !== 4'd7 || r1_rvalid !== 1'b0) begin
            bad++; $display("FAIL haz_issue got pe1=%b a1=%0d rv=%b want 1 7 0", port_enable_1, address_in_1, r1_rvalid);
        end
        advance();
        settle();
        total++;
        if ({r1_rvalid, r0_rvalid} !== 2'b10 || r1_rdata !== 8'h3C) begin
            bad++; $display("FAIL haz_data got rv=%b%b d=%h want 10 3c", r1_rvalid, r0_rvalid, r1_rdata);
        end
        advance();
    endtask

    task automatic test_hazard_other();
        do_reset();
        w0_valid = 1; w0_addr = 4'd9; w0_data = 8'h5A;
        settle(); advance();
        w0_valid = 0;
        r0_valid = 1; r0_addr = 4'd9; r1_valid = 1; r1_addr = 4'd4;
        settle();
        total++;
        if ({r1_ready, r0_ready} !== 2'b10) begin
            bad++; $display("FAIL hzo_other got=%b want=10", {r1_ready, r0_ready});
        end
        advance();
        settle();
        total++;
        if ({r1_ready, r0_ready} !== 2'b01) begin
            bad++; $display("FAIL hzo_ptr got=%b want=01", {r1_ready, r0_ready});
        end
        advance();
        idle_inputs();
        settle();
        total++;
        if ({r1_rvalid, r0_rvalid} !== 2'b10 || r1_rdata !== 8'h05) begin
            bad++; $display("FAIL hzo_r1 got rv=%b%b d=%h want 10 05", r1_rvalid, r0_rvalid, r1_rdata);
        end
        advance();
        settle();
        total++;
        if ({r1_rvalid, r0_rvalid} !== 2'b01 || r0_rdata !== 8'h5A) begin
            bad++; $display("FAIL hzo_r0 got rv=%b%b d=%h want 01 5a", r1_rvalid, r0_rvalid, r0_rdata);
        end
        advance();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        r0_valid = 1; r0_addr = 4'd1; r1_valid = 1; r1_addr = 4'd2;
        settle();
        total++;
        if ({r1_ready, r0_ready} !== 2'b01) begin
            bad++; $display("FAIL mid_first got=%b want=01", {r1_ready, r0_ready});
        end
        advance();
        rst = 1;
        settle();
        total++;
        if ({r1_ready, r0_ready} !== 2'b00) begin
            bad++; $display("FAIL mid_rst_ready got=%b want=00", {r1_ready, r0_ready});
        end
        advance();
        rst = 0;
        settle();
        total++;
        if ({r1_rvalid, r0_rvalid} !== 2'b00 || {r1_ready, r0_ready} !== 2'b01) begin
            bad++; $display("FAIL mid_after got rv=%b%b rdy=%b%b want 00 01", r1_rvalid, r0_rvalid, r1_ready, r0_ready);
        end
        advance();
        idle_inputs();
        settle();
        total++;
        if ({r1_rvalid, r0_rvalid} !== 2'b00) begin
            bad++; $display("FAIL mid_gap got=%b%b want=00", r1_rvalid, r0_rvalid);
        end
        advance();
        settle();
        total++;
        if ({r1_rvalid, r0_rvalid} !== 2'b01 || r0_rdata !== 8'h02) begin
            bad++; $display("FAIL mid_data got rv=%b%b d=%h want 01 02", r1_rvalid, r0_rvalid, r0_rdata);
        end
        advance();
    endtask

    task automatic test_idle();
        do_reset();
        idle_inputs();
        for (int i = 0; i < 10; i++) begin
            settle();
            total++;
            if ({w0_ready, w1_ready, r0_ready, r1_ready, wr_en, port_enable_0,
                 port_enable_1, r0_rvalid, r1_rvalid} !== 9'b0) begin
                bad++; $display("FAIL idle%0d got=%b want=0", i,
                    {w0_ready, w1_ready, r0_ready, r1_ready, wr_en, port_enable_0,
                     port_enable_1, r0_rvalid, r1_rvalid});
            end
            advance();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            // requesters hold a pending request until it is accepted
            if (!w0_valid || e_wg0) begin
                w0_valid = ($urandom % 3) != 0; w0_addr = 4'($urandom); w0_data = 8'($urandom);
            end
            if (!w1_valid || e_wg1) begin
                w1_valid = ($urandom % 3) != 0; w1_addr = 4'($urandom); w1_data = 8'($urandom);
            end
            if (!r0_valid || e_rg0) begin
                r0_valid = ($urandom % 3) != 0;
                r0_addr = (($urandom % 3) == 0) ? ws_a : 4'($urandom);
            end
            if (!r1_valid || e_rg1) begin
                r1_valid = ($urandom % 3) != 0;
                r1_addr = (($urandom % 3) == 0) ? ws_a : 4'($urandom);
            end
            rst = ($urandom % 60) == 0;
            settle();
            total++;
            if ({w1_ready, w0_ready, r1_ready, r0_ready} !== {e_wg1, e_wg0, e_rg1, e_rg0}) begin
                bad++; $display("FAIL rnd_ready c=%0d got=%b want=%b", cyc,
                    {w1_ready, w0_ready, r1_ready, r0_ready}, {e_wg1, e_wg0, e_rg1, e_rg0});
            end
            total++;
            if ({wr_en, port_enable_0, port_enable_1} !== {e_wr_en, e_wr_en, e_pe1}) begin
                bad++; $display("FAIL rnd_strobe c=%0d got=%b want=%b", cyc,
                    {wr_en, port_enable_0, port_enable_1}, {e_wr_en, e_wr_en, e_pe1});
            end
            total++;
            if (address_in_0 !== e_a0 || din !== e_din || address_in_1 !== e_a1) begin
                bad++; $display("FAIL rnd_addr c=%0d got a0=%h d=%h a1=%h want %h %h %h", cyc,
                    address_in_0, din, address_in_1, e_a0, e_din, e_a1);
            end
            total++;
            if ({r1_rvalid, r0_rvalid} !== {e_rv1, e_rv0}) begin
                bad++; $display("FAIL rnd_rvalid c=%0d got=%b%b want=%b%b", cyc, r1_rvalid, r0_rvalid, e_rv1, e_rv0);
            end
            if (e_rv0 || e_rv1) begin
                total++;
                if ((e_rv0 ? r0_rdata : r1_rdata) !== e_rdata) begin
                    bad++; $display("FAIL rnd_rdata c=%0d got=%h want=%h", cyc,
                        e_rv0 ? r0_rdata : r1_rdata, e_rdata);
                end
            end
            advance();
        end
        rst = 0;
        idle_inputs();
    endtask

    initial begin
        rst = 1;
        w0_valid = 0; w1_valid = 0; r0_valid = 0; r1_valid = 0;
        w0_addr = '0; w1_addr = '0; r0_addr = '0; r1_addr = '0;
        w0_data = '0; w1_data = '0;
        @(negedge clk);
        test_reset();
        test_single_write();
        test_write_alt();
        test_fill_readback();
        test_hazard();
        test_hazard_other();
        test_reset_midflight();
        test_idle();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
